fetch_sequencer: RTL and testbench



---
 rtl/fetch_sequencer.sv | 124 ++++++++++++
 tb/tb_fetch_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter, branch-target LUT and run/halt sequencing for the accumulator core
module fetch_sequencer #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [PC_W-1:0]   start_pc,
    input  logic              stall,
    input  logic              halt_req,
    input  logic              branch_en,
    input  logic [LUT_AW-1:0] branch_idx,
    input  logic              jump_taken,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_waddr,
    input  logic [PC_W-1:0]   lut_wdata,
    output logic [PC_W-1:0]   pc,
    output logic              instr_valid,
    output logic              running,
    output logic              done,
    output logic              branch_taken,
    output logic [CNT_W-1:0]  cycle_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam int LUT_DEPTH = 2 ** LUT_AW;
    localparam logic [PC_W-1:0]  PC_LAST = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    state_t            state_next;
    logic [PC_W-1:0]   pc_next;
    logic              done_next;
    logic              branch_next;
    logic              cnt_clear;
    logic [PC_W-1:0]   lut [LUT_DEPTH];
    logic [PC_W-1:0]   branch_target;

    assign running       = (state == RUN);
    assign instr_valid   = running & ~stall;
    assign branch_target = lut[branch_idx];

    always_ff @(posedge CLK) begin
        if (reset) begin
            state        <= IDLE;
            pc           <= '0;
            done         <= 1'b0;
            branch_taken <= 1'b0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            done         <= done_next;
            branch_taken <= branch_next;
        end
    end

    // Stall outranks everything, so a halt or branch under stall is simply re-seen next cycle.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        done_next   = done;
        branch_next = 1'b0;
        cnt_clear   = 1'b0;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_next = RUN;
                    pc_next    = start_pc;
                    done_next  = 1'b0;
                    cnt_clear  = 1'b1;
                end
            end
            RUN: begin
                if (stall) begin
                    pc_next = pc;
                end else if (halt_req) begin
                    state_next = HALT;
                    done_next  = 1'b1;
                end else if (branch_en && jump_taken) begin
                    pc_next     = branch_target;
                    branch_next = 1'b1;
                end else if (pc == PC_LAST) begin
                    // Running off the end of ROM halts rather than wrapping to 0.
                    state_next = HALT;
                    done_next  = 1'b1;
                end else begin
                    pc_next = pc + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                pc_next    = '0;
                done_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset || cnt_clear) begin
            cycle_cnt <= '0;
        end else if (state == RUN && cycle_cnt != CNT_MAX) begin
            cycle_cnt <= cycle_cnt + 1'b1;
        end
    end

    // Table is frozen while a program runs so targets cannot change under it.
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut[i] <= '0;
            end
        end else if (lut_we && state != RUN) begin
            lut[lut_waddr] <= lut_wdata;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  start_pc;
    logic        stall;
    logic        halt_req;
    logic        branch_en;
    logic [4:0]  branch_idx;
    logic        jump_taken;
    logic        lut_we;
    logic [4:0]  lut_waddr;
    logic [9:0]  lut_wdata;

    logic [9:0]  pc;
    logic        instr_valid;
    logic        running;
    logic        done;
    logic        branch_taken;
    logic [15:0] cycle_cnt;

    logic [9:0]  pc4;
    logic        instr_valid4;
    logic        running4;
    logic        done4;
    logic        branch_taken4;
    logic [3:0]  cycle_cnt4;

    int passed = 0;
    int total  = 0;

    always #5 CLK = ~CLK;

    fetch_sequencer #(.PC_W(10), .LUT_AW(5), .CNT_W(16)) u_dut (
        .CLK(CLK), .reset(reset), .start(start), .start_pc(start_pc),
        .stall(stall), .halt_req(halt_req), .branch_en(branch_en),
        .branch_idx(branch_idx), .jump_taken(jump_taken), .lut_we(lut_we),
        .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .pc(pc),
        .instr_valid(instr_valid), .running(running), .done(done),
        .branch_taken(branch_taken), .cycle_cnt(cycle_cnt)
    );

    fetch_sequencer #(.PC_W(10), .LUT_AW(5), .CNT_W(4)) u_dut4 (
        .CLK(CLK), .reset(reset), .start(start), .start_pc(start_pc),
        .stall(stall), .halt_req(halt_req), .branch_en(branch_en),
        .branch_idx(branch_idx), .jump_taken(jump_taken), .lut_we(lut_we),
        .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .pc(pc4),
        .instr_valid(instr_valid4), .running(running4), .done(done4),
        .branch_taken(branch_taken4), .cycle_cnt(cycle_cnt4)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_ctrl();
        start = 0; stall = 0; halt_req = 0; branch_en = 0;
        jump_taken = 0; branch_idx = 0; lut_we = 0; lut_waddr = 0; lut_wdata = 0;
    endtask

    task automatic restart(input logic [9:0] p);
        if (running) begin
            halt_req = 1; step(); halt_req = 0;
        end
        start = 1; start_pc = p; step(); start = 0;
    endtask

    task automatic test_reset();
        clear_ctrl(); start_pc = 0; reset = 1;
        step(); step();
        total++; if (pc !== 10'h000) $display("FAIL reset_pc got %h want 000", pc); else passed++;
        total++; if (running !== 1'b0) $display("FAIL reset_running got %b want 0", running); else passed++;
        total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", instr_valid); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        total++; if (branch_taken !== 1'b0) $display("FAIL reset_bt got %b want 0", branch_taken); else passed++;
        total++; if (cycle_cnt !== 16'd0) $display("FAIL reset_cnt got %0d want 0", cycle_cnt); else passed++;
        reset = 0;
        step();
        total++; if (pc !== 10'h000 || running !== 1'b0) $display("FAIL idle_hold pc %h run %b want 000/0", pc, running); else passed++;
    endtask

    task automatic test_sequential();
        lut_we = 1; lut_waddr = 3; lut_wdata = 10'h040;
        start = 1; start_pc = 10'h010;
        step();
        clear_ctrl();
        total++; if (pc !== 10'h010) $display("FAIL seq_start_pc got %h want 010", pc); else passed++;
        total++; if (running !== 1'b1) $display("FAIL seq_running got %b want 1", running); else passed++;
        total++; if (cycle_cnt !== 16'd0) $display("FAIL seq_cnt0 got %0d want 0", cycle_cnt); else passed++;
        for (int i = 1; i <= 4; i++) begin
            total++; if (instr_valid !== 1'b1) $display("FAIL seq_valid[%0d] got %b want 1", i, instr_valid); else passed++;
            step();
            total++; if (pc !== 10'h010 + 10'(i)) $display("FAIL seq_pc[%0d] got %h want %h", i, pc, 10'h010 + 10'(i)); else passed++;
        end
        total++; if (cycle_cnt !== 16'd4) $display("FAIL seq_cnt4 got %0d want 4", cycle_cnt); else passed++;
        total++; if (done !== 1'b0) $display("FAIL seq_done got %b want 0", done); else passed++;
    endtask

    task automatic test_branch();
        restart(10'h012);
        branch_en = 1; branch_idx = 3; jump_taken = 1;
        step();
        clear_ctrl();
        total++; if (pc !== 10'h040) $display("FAIL br_taken_pc got %h want 040", pc); else passed++;
        total++; if (branch_taken !== 1'b1) $display("FAIL br_taken_pulse got %b want 1", branch_taken); else passed++;
        step();
        total++; if (branch_taken !== 1'b0) $display("FAIL br_pulse_end got %b want 0", branch_taken); else passed++;
        total++; if (pc !== 10'h041) $display("FAIL br_after_pc got %h want 041", pc); else passed++;
        restart(10'h012);
        branch_en = 1; branch_idx = 3; jump_taken = 0;
        step();
        clear_ctrl();
        total++; if (pc !== 10'h013) $display("FAIL br_not_taken_pc got %h want 013", pc); else passed++;
        total++; if (branch_taken !== 1'b0) $display("FAIL br_not_taken_bt got %b want 0", branch_taken); else passed++;
    endtask

    task automatic test_stall();
        restart(10'h020);
        stall = 1; halt_req = 1; branch_en = 1; branch_idx = 3; jump_taken = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (pc !== 10'h020) $display("FAIL stall_pc[%0d] got %h want 020", i, pc); else passed++;
            total++; if (instr_valid !== 1'b0) $display("FAIL stall_valid[%0d] got %b want 0", i, instr_valid); else passed++;
            total++; if (running !== 1'b1) $display("FAIL stall_running[%0d] got %b want 1", i, running); else passed++;
        end
        total++; if (cycle_cnt !== 16'd3) $display("FAIL stall_cnt got %0d want 3", cycle_cnt); else passed++;
        total++; if (branch_taken !== 1'b0) $display("FAIL stall_bt got %b want 0", branch_taken); else passed++;
        stall = 0;
        step();
        clear_ctrl();
        total++; if (running !== 1'b0 || done !== 1'b1) $display("FAIL halt_state run %b done %b want 0/1", running, done); else passed++;
        total++; if (pc !== 10'h020) $display("FAIL halt_pc got %h want 020", pc); else passed++;
        total++; if (branch_taken !== 1'b0) $display("FAIL halt_over_branch_bt got %b want 0", branch_taken); else passed++;
        step();
        total++; if (done !== 1'b1 || pc !== 10'h020) $display("FAIL halt_hold done %b pc %h want 1/020", done, pc); else passed++;
    endtask

    task automatic test_lut_write();
        lut_we = 1; lut_waddr = 5; lut_wdata = 10'h0AA;
        step();
        clear_ctrl();
        restart(10'h030);
        lut_we = 1; lut_waddr = 5; lut_wdata = 10'h155;
        step();
        clear_ctrl();
        total++; if (pc !== 10'h031) $display("FAIL lut_run_pc got %h want 031", pc); else passed++;
        branch_en = 1; branch_idx = 5; jump_taken = 1;
        step();
        clear_ctrl();
        total++; if (pc !== 10'h0AA) $display("FAIL lut_target got %h want 0aa", pc); else passed++;
    endtask

    task automatic test_end_of_rom();
        restart(10'h3FE);
        total++; if (pc !== 10'h3FE) $display("FAIL eor_start got %h want 3fe", pc); else passed++;
        step();
        total++; if (pc !== 10'h3FF || running !== 1'b1) $display("FAIL eor_last pc %h run %b want 3ff/1", pc, running); else passed++;
        step();
        total++; if (running !== 1'b0 || done !== 1'b1) $display("FAIL eor_halt run %b done %b want 0/1", running, done); else passed++;
        total++; if (pc !== 10'h3FF) $display("FAIL eor_nowrap got %h want 3ff", pc); else passed++;
        total++; if (cycle_cnt !== 16'd2) $display("FAIL eor_cnt got %0d want 2", cycle_cnt); else passed++;
        start = 1; start_pc = 10'h3FF;
        step();
        clear_ctrl();
        total++; if (done !== 1'b0 || cycle_cnt !== 16'd0) $display("FAIL restart done %b cnt %0d want 0/0", done, cycle_cnt); else passed++;
        total++; if (running !== 1'b1 || pc !== 10'h3FF) $display("FAIL restart run %b pc %h want 1/3ff", running, pc); else passed++;
        branch_en = 1; branch_idx = 3; jump_taken = 1;
        step();
        clear_ctrl();
        total++; if (pc !== 10'h040 || branch_taken !== 1'b1) $display("FAIL eor_branch pc %h bt %b want 040/1", pc, branch_taken); else passed++;
    endtask

    task automatic test_reset_mid_run();
        restart(10'h055);
        total++; if (pc !== 10'h055) $display("FAIL mid_pc got %h want 055", pc); else passed++;
        reset = 1;
        step();
        reset = 0;
        total++; if (running !== 1'b0 || pc !== 10'h000) $display("FAIL mid_reset run %b pc %h want 0/000", running, pc); else passed++;
        total++; if (done !== 1'b0 || cycle_cnt !== 16'd0) $display("FAIL mid_reset done %b cnt %0d want 0/0", done, cycle_cnt); else passed++;
        start = 1; start_pc = 10'h060;
        step();
        clear_ctrl();
        branch_en = 1; branch_idx = 3; jump_taken = 1;
        step();
        clear_ctrl();
        total++; if (pc !== 10'h000 || branch_taken !== 1'b1) $display("FAIL lut_cleared pc %h bt %b want 000/1", pc, branch_taken); else passed++;
    endtask

    task automatic test_saturation();
        restart(10'h100);
        repeat (20) step();
        total++; if (cycle_cnt !== 16'd20) $display("FAIL cnt20 got %0d want 20", cycle_cnt); else passed++;
        total++; if (cycle_cnt4 !== 4'd15) $display("FAIL cnt_sat got %0d want 15", cycle_cnt4); else passed++;
        total++; if (pc !== 10'h114) $display("FAIL sat_pc got %h want 114", pc); else passed++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_lut_write();
        test_end_of_rom();
        test_reset_mid_run();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
